// File: rtl/pipeline_chain_pkg.sv
// Shared types and helpers for the pipeline register chain.
package pipeline_chain_pkg;

    // Widest destination-register index a stage control word can carry.
    localparam int unsigned WSEL_MAX_W = 16;

    typedef struct packed {
        logic                  valid;
        logic                  wen;
        logic [WSEL_MAX_W-1:0] wsel;
    } stage_ctl_t;

    localparam stage_ctl_t BUBBLE_CTL = '{valid: 1'b0, wen: 1'b0, wsel: '0};

    // Flush indices beyond the last register mean "flush everything".
    function automatic int unsigned clamp_stage(input int unsigned f, input int unsigned nstages);
        return (f >= nstages) ? (nstages - 1) : f;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline register: clear / hold / bubble / load selection plus the flops.
module pipe_stage_reg
    import pipeline_chain_pkg::*;
#(
    parameter int unsigned DW = 64
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          hold,
    input  logic          bubble,
    input  logic          clear,
    input  stage_ctl_t    ld_ctl,
    input  logic [DW-1:0] ld_data,
    output stage_ctl_t    ctl_q,
    output logic [DW-1:0] data_q
);

    stage_ctl_t    ctl_d;
    logic [DW-1:0] data_d;

    // Clear beats hold; bubbles and clears keep the stale payload.
    always_comb begin
        ctl_d  = ctl_q;
        data_d = data_q;
        if (clear) begin
            ctl_d = BUBBLE_CTL;
        end else if (hold) begin
            ctl_d = ctl_q;
        end else if (bubble) begin
            ctl_d = BUBBLE_CTL;
        end else begin
            ctl_d  = ld_ctl;
            data_d = ld_data;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ctl_q  <= BUBBLE_CTL;
            data_q <= '0;
        end else begin
            ctl_q  <= ctl_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/pipeline_chain.sv
// N-stage pipeline register chain with stall/bubble/flush control,
// youngest-writer forwarding lookup and stall/bubble event counters.
module pipeline_chain
    import pipeline_chain_pkg::*;
#(
    parameter  int unsigned NSTAGES = 4,
    parameter  int unsigned DW      = 64,
    parameter  int unsigned RW      = 5,
    localparam int unsigned SW      = $clog2(NSTAGES)
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  in_valid,
    input  logic [DW-1:0]         in_data,
    input  logic                  in_wen,
    input  logic [RW-1:0]         in_wsel,
    output logic                  in_ready,
    input  logic [NSTAGES-1:0]    stall_req,
    input  logic                  flush,
    input  logic [SW-1:0]         flush_stage,
    output logic [NSTAGES-1:0]    stage_valid,
    output logic [NSTAGES*DW-1:0] stage_data,
    output logic                  out_valid,
    output logic [DW-1:0]         out_data,
    input  logic [RW-1:0]         src_sel1,
    input  logic [RW-1:0]         src_sel2,
    output logic                  fwd_hit1,
    output logic                  fwd_hit2,
    output logic [SW-1:0]         fwd_stg1,
    output logic [SW-1:0]         fwd_stg2,
    output logic [DW-1:0]         fwd_data1,
    output logic [DW-1:0]         fwd_data2,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           bubble_cnt
);

    logic [NSTAGES-1:0] hold_c;
    logic [NSTAGES-1:0] bubble_c;
    logic [NSTAGES-1:0] clear_c;
    logic [SW-1:0]      flush_lim;

    stage_ctl_t    ld_ctl  [NSTAGES];
    stage_ctl_t    st_ctl  [NSTAGES];
    logic [DW-1:0] ld_data [NSTAGES];
    logic [DW-1:0] st_data [NSTAGES];

    logic [31:0] stall_cnt_q,  stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic [31:0] bubble_add;

    assign flush_lim = SW'(clamp_stage(32'(flush_stage), NSTAGES));
    assign in_ready  = ~hold_c[0] & ~flush;

    // A stall at stage k freezes k and everything younger.
    generate
        for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
            assign hold_c[k]  = |stall_req[NSTAGES-1:k];
            assign clear_c[k] = flush & (32'(flush_lim) >= 32'(k));

            if (k == 0) begin : g_head
                assign bubble_c[k] = 1'b0;
                assign ld_ctl[k]   = '{valid: in_valid, wen: in_wen, wsel: WSEL_MAX_W'(in_wsel)};
                assign ld_data[k]  = in_data;
            end else begin : g_body
                assign bubble_c[k] = hold_c[k-1] & ~hold_c[k];
                assign ld_ctl[k]   = st_ctl[k-1];
                assign ld_data[k]  = st_data[k-1];
            end

            pipe_stage_reg #(.DW(DW)) u_reg (
                .CLK     (CLK),
                .nRST    (nRST),
                .hold    (hold_c[k]),
                .bubble  (bubble_c[k]),
                .clear   (clear_c[k]),
                .ld_ctl  (ld_ctl[k]),
                .ld_data (ld_data[k]),
                .ctl_q   (st_ctl[k]),
                .data_q  (st_data[k])
            );

            assign stage_valid[k]          = st_ctl[k].valid;
            assign stage_data[k*DW +: DW]  = st_data[k];
        end
    endgenerate

    assign out_valid = st_ctl[NSTAGES-1].valid;
    assign out_data  = st_data[NSTAGES-1];

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_stg1  = '0;
        fwd_data1 = '0;
        fwd_hit2  = 1'b0;
        fwd_stg2  = '0;
        fwd_data2 = '0;
        for (int k = NSTAGES - 1; k >= 0; k--) begin
            if (st_ctl[k].valid && st_ctl[k].wen && (src_sel1 != '0) &&
                (st_ctl[k].wsel == WSEL_MAX_W'(src_sel1))) begin
                fwd_hit1  = 1'b1;
                fwd_stg1  = SW'(k);
                fwd_data1 = st_data[k];
            end
            if (st_ctl[k].valid && st_ctl[k].wen && (src_sel2 != '0) &&
                (st_ctl[k].wsel == WSEL_MAX_W'(src_sel2))) begin
                fwd_hit2  = 1'b1;
                fwd_stg2  = SW'(k);
                fwd_data2 = st_data[k];
            end
        end
    end

    // Bubbles swallowed by a flush are not counted.
    always_comb begin
        bubble_add = '0;
        for (int k = 1; k < NSTAGES; k++) begin
            bubble_add = bubble_add + 32'(bubble_c[k] & ~clear_c[k]);
        end
        stall_cnt_d  = stall_cnt_q + 32'(|stall_req);
        bubble_cnt_d = bubble_cnt_q + bubble_add;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipeline_chain.sv
// Bench for pipeline_chain: directed scenarios plus random traffic against a queue-style model.
module tb_pipeline_chain;

    localparam int NS = 4;
    localparam int DW = 64;
    localparam int RW = 5;
    localparam int SW = 2;

    logic              CLK;
    logic              nRST;
    logic              in_valid;
    logic [DW-1:0]     in_data;
    logic              in_wen;
    logic [RW-1:0]     in_wsel;
    logic              in_ready;
    logic [NS-1:0]     stall_req;
    logic              flush;
    logic [SW-1:0]     flush_stage;
    logic [NS-1:0]     stage_valid;
    logic [NS*DW-1:0]  stage_data;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [RW-1:0]     src_sel1, src_sel2;
    logic              fwd_hit1, fwd_hit2;
    logic [SW-1:0]     fwd_stg1, fwd_stg2;
    logic [DW-1:0]     fwd_data1, fwd_data2;
    logic [31:0]       stall_cnt, bubble_cnt;

    int n_err    = 0;
    int n_checks = 0;
    bit chk_en   = 1'b0;
    bit preload  = 1'b0;

    pipeline_chain #(.NSTAGES(NS), .DW(DW), .RW(RW)) dut (
        .CLK(CLK), .nRST(nRST),
        .in_valid(in_valid), .in_data(in_data), .in_wen(in_wen), .in_wsel(in_wsel),
        .in_ready(in_ready), .stall_req(stall_req), .flush(flush), .flush_stage(flush_stage),
        .stage_valid(stage_valid), .stage_data(stage_data),
        .out_valid(out_valid), .out_data(out_data),
        .src_sel1(src_sel1), .src_sel2(src_sel2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_stg1(fwd_stg1), .fwd_stg2(fwd_stg2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic          m_v [NS];
    logic          m_w [NS];
    logic [RW-1:0] m_s [NS];
    logic [DW-1:0] m_d [NS];
    logic [31:0]   m_stall, m_bub;

    // Index of the oldest stalled stage, -1 when nothing stalls.
    function automatic int m_top();
        int t = -1;
        for (int j = 0; j < NS; j++) if (stall_req[j]) t = j;
        return t;
    endfunction

    // Highest flushed stage, -1 when not flushing.
    function automatic int m_fl();
        if (!flush) return -1;
        return (int'(flush_stage) >= NS) ? NS - 1 : int'(flush_stage);
    endfunction

    function automatic int m_nbub();
        int n = 0;
        for (int k = 1; k < NS; k++)
            if (k > m_top() && (k - 1) <= m_top() && k > m_fl()) n++;
        return n;
    endfunction

    function automatic void m_lookup(input logic [RW-1:0] s, output logic h,
                                     output logic [SW-1:0] g, output logic [DW-1:0] d);
        h = 1'b0; g = '0; d = '0;
        if (s != '0)
            for (int k = 0; k < NS; k++)
                if (!h && m_v[k] && m_w[k] && m_s[k] == s) begin
                    h = 1'b1; g = SW'(k); d = m_d[k];
                end
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int k = 0; k < NS; k++) begin
                m_v[k] <= 1'b0; m_w[k] <= 1'b0; m_s[k] <= '0; m_d[k] <= '0;
            end
            m_stall <= '0;
            m_bub   <= '0;
        end else begin
            for (int k = 0; k < NS; k++) begin
                if (k <= m_fl()) begin
                    m_v[k] <= 1'b0; m_w[k] <= 1'b0;
                end else if (k <= m_top()) begin
                    m_v[k] <= m_v[k];
                end else if (k == 0) begin
                    m_v[k] <= in_valid; m_w[k] <= in_wen; m_s[k] <= in_wsel; m_d[k] <= in_data;
                end else if ((k - 1) <= m_top()) begin
                    m_v[k] <= 1'b0; m_w[k] <= 1'b0;
                end else begin
                    m_v[k] <= m_v[k-1]; m_w[k] <= m_w[k-1]; m_s[k] <= m_s[k-1]; m_d[k] <= m_d[k-1];
                end
            end
            m_stall <= (preload ? 32'hFFFF_FFFF : m_stall) + ((stall_req != '0) ? 32'd1 : 32'd0);
            m_bub   <= m_bub + 32'(m_nbub());
        end
    end

    // ---------------- per-cycle compare ----------------
    logic          e_h1, e_h2;
    logic [SW-1:0] e_g1, e_g2;
    logic [DW-1:0] e_d1, e_d2;

    always @(negedge CLK) begin
        if (nRST && chk_en) begin
            m_lookup(src_sel1, e_h1, e_g1, e_d1);
            m_lookup(src_sel2, e_h2, e_g2, e_d2);
            chk("in_ready", in_ready, (stall_req == '0) && !flush);
            for (int k = 0; k < NS; k++) begin
                chk($sformatf("stage_valid[%0d]", k), stage_valid[k], m_v[k]);
                chk($sformatf("stage_data[%0d]", k), stage_data[k*DW +: DW], m_d[k]);
            end
            chk("out_valid", out_valid, m_v[NS-1]);
            chk("out_data", out_data, m_d[NS-1]);
            chk("fwd_hit1", fwd_hit1, e_h1);
            chk("fwd_stg1", fwd_stg1, e_g1);
            chk("fwd_data1", fwd_data1, e_d1);
            chk("fwd_hit2", fwd_hit2, e_h2);
            chk("fwd_stg2", fwd_stg2, e_g2);
            chk("fwd_data2", fwd_data2, e_d2);
            chk("stall_cnt", stall_cnt, m_stall);
            chk("bubble_cnt", bubble_cnt, m_bub);
        end
    end

    task automatic edge1();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic w, input logic [RW-1:0] s);
        in_valid = v; in_data = d; in_wen = w; in_wsel = s;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        nRST = 1'b0;
        drive(1'b0, '0, 1'b0, '0);
        stall_req = '0; flush = 1'b0; flush_stage = '0;
        src_sel1 = '0; src_sel2 = '0;
        #2;
        chk("reset stage_valid", stage_valid, '0);
        chk("reset stall_cnt", stall_cnt, '0);
        chk("reset bubble_cnt", bubble_cnt, '0);
        chk("reset out_valid", out_valid, 1'b0);
        edge1();
        edge1();
        nRST   = 1'b1;
        chk_en = 1'b1;

        // Free flow: 0xA..0xD
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, DW'(64'hA + 64'(i)), 1'b1, RW'(i + 1));
            edge1();
        end
        drive(1'b0, '0, 1'b0, '0);
        chk("flow out_valid", out_valid, 1'b1);
        chk("flow out_data", out_data, 64'hA);
        chk("flow stage0", stage_data[0 +: DW], 64'hD);
        chk("flow bubble_cnt", bubble_cnt, 32'd0);

        // Stall stage 2 for two cycles while full
        stall_req = 4'b0100;
        edge1();
        chk("stall out_valid #1", out_valid, 1'b0);
        edge1();
        chk("stall out_valid #2", out_valid, 1'b0);
        chk("stall bubble_cnt", bubble_cnt, 32'd2);
        chk("stall stall_cnt", stall_cnt, 32'd2);
        chk("stall stage2 frozen", stage_data[2*DW +: DW], 64'hB);
        stall_req = '0;
        edge1();
        chk("resume out_valid", out_valid, 1'b1);
        chk("resume out_data", out_data, 64'hB);

        // Writers of r5 at stages 1 and 3
        drive(1'b1, 64'h50, 1'b1, 5'd5); edge1();
        drive(1'b1, 64'h61, 1'b1, 5'd6); edge1();
        drive(1'b1, 64'h52, 1'b1, 5'd5); edge1();
        drive(1'b1, 64'h63, 1'b1, 5'd6); edge1();
        drive(1'b0, '0, 1'b0, '0);
        src_sel1 = 5'd5; src_sel2 = 5'd0;
        #1;
        chk("fwd r5 hit", fwd_hit1, 1'b1);
        chk("fwd r5 stg", fwd_stg1, 2'd1);
        chk("fwd r5 data", fwd_data1, 64'h52);
        chk("fwd r0 hit", fwd_hit2, 1'b0);
        chk("fwd r0 data", fwd_data2, 64'h0);

        // Partial flush through stage 1 with stage 0 stalled
        flush = 1'b1; flush_stage = 2'd1; stall_req = 4'b0001;
        drive(1'b1, 64'hEE, 1'b1, 5'd3);
        #1;
        chk("flush in_ready", in_ready, 1'b0);
        edge1();
        flush = 1'b0; stall_req = '0;
        drive(1'b0, '0, 1'b0, '0);
        chk("flush stage_valid", stage_valid, 4'b1100);
        chk("flush stage2", stage_data[2*DW +: DW], 64'h52);
        chk("flush stage3", stage_data[3*DW +: DW], 64'h61);
        chk("flush stage0 not captured", stage_data[0 +: DW], 64'h63);

        // Async reset in the middle of a stall
        stall_req = 4'b0100;
        drive(1'b1, 64'h77, 1'b1, 5'd2);
        edge1();
        #2;
        nRST = 1'b0;
        #1;
        chk("async rst stage_valid", stage_valid, '0);
        chk("async rst stall_cnt", stall_cnt, '0);
        chk("async rst bubble_cnt", bubble_cnt, '0);
        nRST = 1'b1;
        stall_req = '0;

        // stall_cnt wrap
        edge1();
        chk_en  = 1'b0;
        preload = 1'b1;
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        stall_req = 4'b0001;
        #1;
        release dut.stall_cnt_q;
        chk("wrap preload", stall_cnt, 32'hFFFF_FFFF);
        edge1();
        preload = 1'b0;
        chk("wrap stall_cnt", stall_cnt, 32'd0);
        chk_en  = 1'b1;
        stall_req = '0;

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            edge1();
            drive(1'($urandom), {$urandom, $urandom}, 1'($urandom), RW'($urandom_range(0, 7)));
            stall_req   = ($urandom_range(0, 3) == 0) ? NS'($urandom) : '0;
            flush       = ($urandom_range(0, 9) == 0);
            flush_stage = SW'($urandom);
            src_sel1    = RW'($urandom_range(0, 7));
            src_sel2    = RW'($urandom_range(0, 7));
        end
        edge1();
        stall_req = '0; flush = 1'b0;
        edge1();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
